// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage pipeline register. One instance sits on each stage
// boundary (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries LANES x DATA_W bits of
// payload plus the exception / PC / delay-slot side-band. It is steered by
// the stall controller's stall vector and by the exception unit's flush.
//
// Each rising edge performs exactly one action, in this priority order:
//   RESET   rst                 every output register cleared
//   FLUSH   flush               payload, valid, side-band and hold cleared
//   BUBBLE  s_up & ~s_dn        valid/side-band cleared, payload = in & KEEP_MASK
//   HOLD    s_up &  s_dn        everything kept, out_hold set
//   ADVANCE ~s_up               everything loaded from the inputs
// Here s_up = stall[STAGE], and s_dn = stall[STAGE+1] (or 0 when STAGE is
// the last bit of the stall vector). The pattern ~s_up & s_dn cannot come
// from a well-behaved stall controller, and it is treated as ADVANCE.
//
// Optional feature, macro PIPE_STAGE_PERF_EN:
//   adds saturating HOLD / BUBBLE edge counters (hold_cnt, bubble_cnt).
//   These clear only on rst. A flush does not clear them.
//
// Parameters:
//   DATA_W     payload bits per lane
//   LANES      number of issue lanes (1..4)
//   STALL_W    width of the stall vector
//   STAGE      index of this register's upstream-stage bit in stall
//   KEEP_MASK  per-lane payload bits that survive a bubble
//   CNT_W      width of the performance counters
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   stall, flush        stall vector and exception flush
//   in_valid, in_data   per-lane valid and payload (lane k at [k*DATA_W +: DATA_W])
//   in_excepttype       exception word shared by all lanes
//   in_pc               PC of the lane-0 instruction
//   in_delayslot        instruction is in a delay slot
//   in_next_delayslot   next instruction will be in a delay slot
//   out_*               registered copies of the inputs above
//   out_hold            the previous edge performed HOLD
//   hold_cnt            HOLD edge counter   (PIPE_STAGE_PERF_EN only)
//   bubble_cnt          BUBBLE edge counter (PIPE_STAGE_PERF_EN only)
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int                DATA_W    = 64,
  parameter int                LANES     = 1,
  parameter int                STALL_W   = 6,
  parameter int                STAGE     = 2,
  parameter logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_W-1:0]      stall,
  input  logic                    flush,
  input  logic [LANES-1:0]        in_valid,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [31:0]             in_excepttype,
  input  logic [31:0]             in_pc,
  input  logic                    in_delayslot,
  input  logic                    in_next_delayslot,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [31:0]             out_excepttype,
  output logic [31:0]             out_pc,
  output logic                    out_delayslot,
  output logic                    out_next_delayslot,
  output logic                    out_hold
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]        hold_cnt,
  output logic [CNT_W-1:0]        bubble_cnt
`endif
);

  // The keep mask applies to every lane in the same way, so it is
  // replicated once across the whole payload word.
  localparam logic [LANES*DATA_W-1:0] KEEP_ALL = {LANES{KEEP_MASK}};

  // The action chosen for the coming edge. Reset is not listed here. It is
  // handled directly in the register process because it also clears the
  // counters.
  typedef enum logic [1:0] {
    ACT_ADVANCE = 2'd0,
    ACT_BUBBLE  = 2'd1,
    ACT_HOLD    = 2'd2,
    ACT_FLUSH   = 2'd3
  } action_e;

  action_e action;

  logic s_up;
  logic s_dn;

  logic [LANES-1:0]        valid_d;
  logic [LANES*DATA_W-1:0] data_d;
  logic [31:0]             excepttype_d;
  logic [31:0]             pc_d;
  logic                    delayslot_d;
  logic                    next_delayslot_d;
  logic                    hold_d;

  // Only two bits of the stall vector matter to this instance. The whole
  // vector is still routed to every instance so the wiring is uniform.
  logic unused_stall_bits;
  assign unused_stall_bits = ^stall;

  assign s_up = stall[STAGE];

  // The stage at the end of the stall vector has no downstream bit.
  // A stall there can only ever bubble.
  generate
    if (STAGE + 1 < STALL_W) begin : g_dn_bit
      assign s_dn = stall[STAGE+1];
    end else begin : g_no_dn_bit
      assign s_dn = 1'b0;
    end
  endgenerate

  // Pick the action for this edge. Flush beats any stall pattern. The
  // illegal ~s_up & s_dn pattern falls through to ADVANCE on purpose. This
  // keeps the pipe moving instead of freezing on a stall-controller bug.
  always_comb begin
    action = ACT_ADVANCE;
    if (flush) begin
      action = ACT_FLUSH;
    end else if (s_up && !s_dn) begin
      action = ACT_BUBBLE;
    end else if (s_up && s_dn) begin
      action = ACT_HOLD;
    end
  end

  // Next-value selection for the payload and side-band registers. HOLD is
  // the default, so every register starts from its current value. A lane
  // whose in_valid is low still loads its payload on ADVANCE. Downstream
  // logic is expected to qualify the payload with out_valid.
  always_comb begin
    valid_d          = out_valid;
    data_d           = out_data;
    excepttype_d     = out_excepttype;
    pc_d             = out_pc;
    delayslot_d      = out_delayslot;
    next_delayslot_d = out_next_delayslot;
    hold_d           = 1'b1;
    case (action)
      ACT_FLUSH: begin
        valid_d          = '0;
        data_d           = '0;
        excepttype_d     = '0;
        pc_d             = '0;
        delayslot_d      = 1'b0;
        next_delayslot_d = 1'b0;
        hold_d           = 1'b0;
      end
      ACT_BUBBLE: begin
        valid_d          = '0;
        data_d           = in_data & KEEP_ALL;
        excepttype_d     = '0;
        pc_d             = '0;
        delayslot_d      = 1'b0;
        next_delayslot_d = 1'b0;
        hold_d           = 1'b0;
      end
      ACT_HOLD: begin
        hold_d           = 1'b1;
      end
      default: begin
        valid_d          = in_valid;
        data_d           = in_data;
        excepttype_d     = in_excepttype;
        pc_d             = in_pc;
        delayslot_d      = in_delayslot;
        next_delayslot_d = in_next_delayslot;
        hold_d           = 1'b0;
      end
    endcase
  end

  // The output registers themselves. Reset clears them on the same edge it
  // is sampled. After that, the next edge acts on whatever the inputs are
  // at that time, even if the stall pattern was HOLD during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid          <= '0;
      out_data           <= '0;
      out_excepttype     <= '0;
      out_pc             <= '0;
      out_delayslot      <= 1'b0;
      out_next_delayslot <= 1'b0;
      out_hold           <= 1'b0;
    end else begin
      out_valid          <= valid_d;
      out_data           <= data_d;
      out_excepttype     <= excepttype_d;
      out_pc             <= pc_d;
      out_delayslot      <= delayslot_d;
      out_next_delayslot <= next_delayslot_d;
      out_hold           <= hold_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating count of HOLD edges. It stops at all-ones so a long stall
  // cannot wrap it back to a small value. Only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if ((action == ACT_HOLD) && (hold_cnt != CNT_MAX)) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  // Saturating count of BUBBLE edges. It uses the same rules as the hold
  // counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if ((action == ACT_BUBBLE) && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`else
  // Without the counters the width parameter has no use. This keeps it
  // referenced so that both builds take the same parameter list.
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Three instances share one set of stimulus:
//   u_a  DATA_W=64, LANES=1, STAGE=2, keep low 32 bits, CNT_W=16
//   u_b  DATA_W=64, LANES=2, STAGE=2, keep top/bottom byte, CNT_W=2
//   u_c  DATA_W=8,  LANES=1, STAGE=5 (last stall bit, no downstream), CNT_W=4
// A rule-level model predicts every output after every edge. Literal
// expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic         flush;
  logic [1:0]   in_valid;
  logic [127:0] in_data;
  logic [31:0]  in_excepttype;
  logic [31:0]  in_pc;
  logic         in_delayslot;
  logic         in_next_delayslot;

  logic [0:0]   a_valid;
  logic [63:0]  a_data;
  logic [31:0]  a_exc, a_pc;
  logic         a_ds, a_nds, a_hold;
  logic [1:0]   b_valid;
  logic [127:0] b_data;
  logic [31:0]  b_exc, b_pc;
  logic         b_ds, b_nds, b_hold;
  logic [0:0]   c_valid;
  logic [7:0]   c_data;
  logic [31:0]  c_exc, c_pc;
  logic         c_ds, c_nds, c_hold;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]  a_hcnt, a_bcnt;
  logic [1:0]   b_hcnt, b_bcnt;
  logic [3:0]   c_hcnt, c_bcnt;
`endif

  int checks = 0;
  int failures = 0;

  pipe_stage_reg #(.DATA_W(64), .LANES(1), .STALL_W(6), .STAGE(2),
                   .KEEP_MASK(64'h0000_0000_FFFF_FFFF), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid[0:0]), .in_data(in_data[63:0]),
    .in_excepttype(in_excepttype), .in_pc(in_pc),
    .in_delayslot(in_delayslot), .in_next_delayslot(in_next_delayslot),
    .out_valid(a_valid), .out_data(a_data), .out_excepttype(a_exc),
    .out_pc(a_pc), .out_delayslot(a_ds), .out_next_delayslot(a_nds),
    .out_hold(a_hold)
`ifdef PIPE_STAGE_PERF_EN
    , .hold_cnt(a_hcnt), .bubble_cnt(a_bcnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(64), .LANES(2), .STALL_W(6), .STAGE(2),
                   .KEEP_MASK(64'hFF00_0000_0000_00FF), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_data(in_data),
    .in_excepttype(in_excepttype), .in_pc(in_pc),
    .in_delayslot(in_delayslot), .in_next_delayslot(in_next_delayslot),
    .out_valid(b_valid), .out_data(b_data), .out_excepttype(b_exc),
    .out_pc(b_pc), .out_delayslot(b_ds), .out_next_delayslot(b_nds),
    .out_hold(b_hold)
`ifdef PIPE_STAGE_PERF_EN
    , .hold_cnt(b_hcnt), .bubble_cnt(b_bcnt)
`endif
  );

  pipe_stage_reg #(.DATA_W(8), .LANES(1), .STALL_W(6), .STAGE(5),
                   .KEEP_MASK(8'h0F), .CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid[0:0]), .in_data(in_data[7:0]),
    .in_excepttype(in_excepttype), .in_pc(in_pc),
    .in_delayslot(in_delayslot), .in_next_delayslot(in_next_delayslot),
    .out_valid(c_valid), .out_data(c_data), .out_excepttype(c_exc),
    .out_pc(c_pc), .out_delayslot(c_ds), .out_next_delayslot(c_nds),
    .out_hold(c_hold)
`ifdef PIPE_STAGE_PERF_EN
    , .hold_cnt(c_hcnt), .bubble_cnt(c_bcnt)
`endif
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Per-instance configuration as seen by the model.
  int           m_lanes  [3] = '{1, 2, 1};
  int           m_dw     [3] = '{64, 64, 8};
  int           m_stage  [3] = '{2, 2, 5};
  int           m_cntmax [3] = '{65535, 3, 15};
  logic [127:0] m_keep   [3];

  // Predicted outputs.
  logic [1:0]   e_valid [3];
  logic [127:0] e_data  [3];
  logic [31:0]  e_exc   [3];
  logic [31:0]  e_pc    [3];
  logic         e_ds    [3];
  logic         e_nds   [3];
  logic         e_hold  [3];
  int           e_hcnt  [3];
  int           e_bcnt  [3];
  bit           model_live = 0;

  initial begin
    m_keep[0] = 128'h0000_0000_FFFF_FFFF;
    m_keep[1] = {64'hFF00_0000_0000_00FF, 64'hFF00_0000_0000_00FF};
    m_keep[2] = 128'h0F;
  end

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the action rules of one edge to instance i's predicted state.
  task automatic modelStep(input int i);
    logic         su, sd;
    logic [127:0] wmask;
    logic [1:0]   vmask;
    wmask = (128'd1 << (m_lanes[i] * m_dw[i])) - 128'd1;
    vmask = (m_lanes[i] == 2) ? 2'b11 : 2'b01;
    su = stall[m_stage[i]];
    sd = 1'b0;
    if (m_stage[i] + 1 < 6) sd = stall[m_stage[i] + 1];
    if (rst || flush) begin
      e_valid[i] = '0; e_data[i] = '0; e_exc[i] = '0; e_pc[i] = '0;
      e_ds[i] = 1'b0; e_nds[i] = 1'b0; e_hold[i] = 1'b0;
      if (rst) begin
        e_hcnt[i] = 0;
        e_bcnt[i] = 0;
      end
    end else if (su && !sd) begin
      e_valid[i] = '0; e_data[i] = in_data & m_keep[i] & wmask;
      e_exc[i] = '0; e_pc[i] = '0; e_ds[i] = 1'b0; e_nds[i] = 1'b0;
      e_hold[i] = 1'b0;
      if (e_bcnt[i] < m_cntmax[i]) e_bcnt[i]++;
    end else if (su && sd) begin
      e_hold[i] = 1'b1;
      if (e_hcnt[i] < m_cntmax[i]) e_hcnt[i]++;
    end else begin
      e_valid[i] = in_valid & vmask; e_data[i] = in_data & wmask;
      e_exc[i] = in_excepttype; e_pc[i] = in_pc;
      e_ds[i] = in_delayslot; e_nds[i] = in_next_delayslot; e_hold[i] = 1'b0;
    end
  endtask

  task automatic compareAll();
    checkOutput("a.valid", 128'(a_valid), 128'(e_valid[0]));
    checkOutput("a.data",  128'(a_data),  e_data[0]);
    checkOutput("a.exc",   128'(a_exc),   128'(e_exc[0]));
    checkOutput("a.pc",    128'(a_pc),    128'(e_pc[0]));
    checkOutput("a.ds",    128'(a_ds),    128'(e_ds[0]));
    checkOutput("a.nds",   128'(a_nds),   128'(e_nds[0]));
    checkOutput("a.hold",  128'(a_hold),  128'(e_hold[0]));
    checkOutput("b.valid", 128'(b_valid), 128'(e_valid[1]));
    checkOutput("b.data",  b_data,        e_data[1]);
    checkOutput("b.exc",   128'(b_exc),   128'(e_exc[1]));
    checkOutput("b.pc",    128'(b_pc),    128'(e_pc[1]));
    checkOutput("b.ds",    128'(b_ds),    128'(e_ds[1]));
    checkOutput("b.nds",   128'(b_nds),   128'(e_nds[1]));
    checkOutput("b.hold",  128'(b_hold),  128'(e_hold[1]));
    checkOutput("c.valid", 128'(c_valid), 128'(e_valid[2]));
    checkOutput("c.data",  128'(c_data),  e_data[2]);
    checkOutput("c.exc",   128'(c_exc),   128'(e_exc[2]));
    checkOutput("c.pc",    128'(c_pc),    128'(e_pc[2]));
    checkOutput("c.ds",    128'(c_ds),    128'(e_ds[2]));
    checkOutput("c.nds",   128'(c_nds),   128'(e_nds[2]));
    checkOutput("c.hold",  128'(c_hold),  128'(e_hold[2]));
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("a.hold_cnt",   128'(a_hcnt), 128'(e_hcnt[0]));
    checkOutput("a.bubble_cnt", 128'(a_bcnt), 128'(e_bcnt[0]));
    checkOutput("b.hold_cnt",   128'(b_hcnt), 128'(e_hcnt[1]));
    checkOutput("b.bubble_cnt", 128'(b_bcnt), 128'(e_bcnt[1]));
    checkOutput("c.hold_cnt",   128'(c_hcnt), 128'(e_hcnt[2]));
    checkOutput("c.bubble_cnt", 128'(c_bcnt), 128'(e_bcnt[2]));
`endif
  endtask

  // Model update on every edge, then compare once the DUT registers settle.
  // Outputs are meaningful from the first reset edge onward.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) modelStep(i);
    if (rst) model_live = 1;
    #1;
    if (model_live) compareAll();
  end

  // u_a and u_b sit at stage 2. A stall controller must never request
  // stall[3] without stall[2].
  always @(posedge clk) begin
    if (!rst && !flush)
      assert (!(!stall[2] && stall[3]))
        else $error("[TB] illegal stall pattern %b for STAGE=2", stall);
  end

  task automatic applyStimulus(input logic r, input logic f, input logic [5:0] s,
                               input logic [1:0] v, input logic [127:0] d,
                               input logic [31:0] e, input logic [31:0] p,
                               input logic ds, input logic nds);
    @(negedge clk);
    rst = r; flush = f; stall = s; in_valid = v; in_data = d;
    in_excepttype = e; in_pc = p; in_delayslot = ds; in_next_delayslot = nds;
    @(posedge clk);
    #2;
  endtask

  logic [5:0] loop_stall [8] = '{6'b000000, 6'b000100, 6'b001100, 6'b111111,
                                 6'b100000, 6'b000111, 6'b110100, 6'b000000};

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0; in_valid = 2'b11; in_data = '1;
    in_excepttype = '0; in_pc = '0; in_delayslot = 1'b0; in_next_delayslot = 1'b0;

    // Reset with all-ones data and valid asserted.
    applyStimulus(1, 0, 6'b000000, 2'b11, {128{1'b1}}, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
    checkOutput("lit.reset.a_data", 128'(a_data), 128'h0);
    checkOutput("lit.reset.a_valid", 128'(a_valid), 128'h0);
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("lit.reset.a_hold_cnt", 128'(a_hcnt), 128'h0);
`endif

    // Advance.
    applyStimulus(0, 0, 6'b000000, 2'b01, {64'hDEAD_BEEF_0000_1111, 64'h1234_5678_9ABC_DEF0},
                  32'h0000_0010, 32'hBFC0_0010, 1, 0);
    checkOutput("lit.adv.a_data", 128'(a_data), 128'h1234_5678_9ABC_DEF0);
    checkOutput("lit.adv.a_pc", 128'(a_pc), 128'hBFC0_0010);
    checkOutput("lit.adv.a_hold", 128'(a_hold), 128'h0);

    // Bubble with keep mask. u_c is not stalled by this pattern.
    applyStimulus(0, 0, 6'b000111, 2'b11, {64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD},
                  32'h0000_0020, 32'hBFC0_0014, 0, 1);
    checkOutput("lit.bub.a_data", 128'(a_data), 128'h0000_0000_CCCC_DDDD);
    checkOutput("lit.bub.a_valid", 128'(a_valid), 128'h0);
    checkOutput("lit.bub.b_data", b_data, {64'h1100_0000_0000_0044, 64'hAA00_0000_0000_00DD});
    checkOutput("lit.bub.c_data", 128'(c_data), 128'hDD);
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("lit.bub.a_bubble_cnt", 128'(a_bcnt), 128'h1);
`endif

    // Advance 0x55, then hold three edges with new data 0x99.
    applyStimulus(0, 0, 6'b000000, 2'b11, {64'h66, 64'h55}, 32'h0, 32'h100, 0, 0);
    for (int k = 0; k < 3; k++)
      applyStimulus(0, 0, 6'b001111, 2'b11, {64'h77, 64'h99}, 32'h0, 32'h104, 1, 1);
    checkOutput("lit.hold.a_data", 128'(a_data), 128'h55);
    checkOutput("lit.hold.a_hold", 128'(a_hold), 128'h1);
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("lit.hold.a_hold_cnt", 128'(a_hcnt), 128'h3);
`endif
    applyStimulus(0, 0, 6'b000000, 2'b11, {64'h77, 64'h99}, 32'h0, 32'h104, 1, 1);
    checkOutput("lit.release.a_data", 128'(a_data), 128'h99);
    checkOutput("lit.release.a_hold", 128'(a_hold), 128'h0);

    // Flush beats a HOLD pattern and does not touch the counters.
    applyStimulus(0, 0, 6'b001111, 2'b11, {64'h1, 64'h2}, 32'h0, 32'h108, 0, 0);
    applyStimulus(0, 1, 6'b001111, 2'b11, {64'h3, 64'h4}, 32'h0000_0200, 32'h10C, 1, 1);
    checkOutput("lit.flush.a_exc", 128'(a_exc), 128'h0);
    checkOutput("lit.flush.a_data", 128'(a_data), 128'h0);
    checkOutput("lit.flush.a_hold", 128'(a_hold), 128'h0);
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("lit.flush.a_hold_cnt", 128'(a_hcnt), 128'h4);
`endif

    // Reset during a HOLD pattern, then saturate the 2-bit counter of u_b.
    applyStimulus(1, 0, 6'b001111, 2'b11, {64'hAB, 64'hCD}, 32'h5, 32'h200, 1, 1);
    checkOutput("lit.rsthold.a_data", 128'(a_data), 128'h0);
    applyStimulus(0, 0, 6'b000000, 2'b11, {64'hBEEF, 64'hCAFE}, 32'h6, 32'h204, 0, 1);
    for (int k = 0; k < 5; k++)
      applyStimulus(0, 0, 6'b001111, 2'b01, {64'h1234, 64'h5678}, 32'h7, 32'h208, 1, 0);
`ifdef PIPE_STAGE_PERF_EN
    checkOutput("lit.sat.b_hold_cnt", 128'(b_hcnt), 128'h3);
    checkOutput("lit.sat.a_hold_cnt", 128'(a_hcnt), 128'h5);
`endif
    applyStimulus(0, 0, 6'b000000, 2'b10, {64'h0123_4567_89AB_CDEF, 64'h0F0F},
                  32'h8, 32'h20C, 0, 0);
    checkOutput("lit.lanes.b_valid", 128'(b_valid), 128'h2);
    checkOutput("lit.lanes.b_data", b_data, {64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0F0F});

    // Last stall bit: u_c bubbles, while u_a and u_b advance.
    applyStimulus(0, 0, 6'b100000, 2'b11, {64'h0, 64'h1234_5678_0000_00A7},
                  32'h9, 32'h210, 1, 1);
    checkOutput("lit.edge.c_data", 128'(c_data), 128'h07);
    checkOutput("lit.edge.c_valid", 128'(c_valid), 128'h0);
    checkOutput("lit.edge.a_data", 128'(a_data), 128'h1234_5678_0000_00A7);
    applyStimulus(0, 0, 6'b111111, 2'b11, {64'h0, 64'hF3}, 32'hA, 32'h214, 0, 0);
    checkOutput("lit.edge2.c_data", 128'(c_data), 128'h03);
    checkOutput("lit.edge2.a_hold", 128'(a_hold), 128'h1);

    // Mixed legal patterns, checked by the model on every edge.
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, (k == 11), loop_stall[k % 8], 2'(k),
                    {64'hC0DE_0000_0000_0000 | 64'(k), 64'hF00D_0000_0000_0000 ^ 64'(k * 3)},
                    32'(k << 8), 32'h8000_0000 + 32'(k * 4), k[0], k[1]);
    end

    applyStimulus(0, 0, 6'b000000, 2'b00, '0, '0, '0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
